// File: rtl/plot_sequencer.sv
// plot_sequencer
//   Sole driver of the vga_adapter pixel-write port. After reset, or when
//   clear_req pulses, it sweeps the whole X_MAX x Y_MAX screen with BG_COLOUR,
//   one pixel per clock. On each movement tick it snapshots the four player
//   positions and plots them on four consecutive cycles, one per player.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   reset        in   synchronous active-high reset, restarts the clear sweep
//   clear_req    in   one-cycle pulse: restart a full-screen clear
//   tick         in   one-cycle movement strobe: plot current positions
//   p1..p4       in   player positions, [14:7]=x, [6:0]=y
//   x, y         out  pixel coordinate to vga_adapter
//   colour       out  pixel colour to vga_adapter
//   plot         out  pixel write enable to vga_adapter
//   busy         out  high while clearing or drawing
//   clear_done   out  one-cycle pulse after the last clear pixel
module plot_sequencer #(
   parameter int unsigned X_MAX     = 160,
   parameter int unsigned Y_MAX     = 120,
   parameter logic [2:0]  BG_COLOUR = 3'b000,
   parameter logic [2:0]  P1_COLOUR = 3'b001,
   parameter logic [2:0]  P2_COLOUR = 3'b010,
   parameter logic [2:0]  P3_COLOUR = 3'b100,
   parameter logic [2:0]  P4_COLOUR = 3'b110
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        clear_req,
   input  logic        tick,
   input  logic [14:0] p1,
   input  logic [14:0] p2,
   input  logic [14:0] p3,
   input  logic [14:0] p4,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        busy,
   output logic        clear_done
);

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      DRAW_P1,
      DRAW_P2,
      DRAW_P3,
      DRAW_P4
   } state_t;

   state_t      state;
   logic [7:0]  cx;
   logic [6:0]  cy;
   logic        sweep_end;   // last clear pixel is on the outputs
   logic        pending;     // tick seen while busy, serviced in IDLE
   logic [14:0] snap2, snap3, snap4;

   function automatic logic on_screen(input logic [14:0] pos);
      return (pos[14:7] < 8'(X_MAX)) && (pos[6:0] < 7'(Y_MAX));
   endfunction

   // Outputs are registered, so each state's pixel is loaded on the edge that
   // enters it: p1 is plotted straight from the live inputs on the snapshot
   // edge, which is why only p2..p4 need snapshot registers.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= CLEAR;
         cx         <= '0;
         cy         <= '0;
         sweep_end  <= 1'b0;
         pending    <= 1'b0;
         snap2      <= '0;
         snap3      <= '0;
         snap4      <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= BG_COLOUR;
         plot       <= 1'b0;
         busy       <= 1'b1;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         if (clear_req) begin
            // Pixel (0,0) goes out on this edge; the counters continue from (1,0).
            state     <= CLEAR;
            cx        <= 8'd1;
            cy        <= '0;
            sweep_end <= 1'b0;
            pending   <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= BG_COLOUR;
            plot      <= 1'b1;
            busy      <= 1'b1;
         end else begin
            case (state)
               CLEAR: begin
                  pending <= pending | tick;
                  if (sweep_end) begin
                     sweep_end  <= 1'b0;
                     plot       <= 1'b0;
                     busy       <= 1'b0;
                     clear_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     x      <= cx;
                     y      <= cy;
                     colour <= BG_COLOUR;
                     plot   <= 1'b1;
                     busy   <= 1'b1;
                     if (cx == 8'(X_MAX - 1)) begin
                        cx <= '0;
                        if (cy == 7'(Y_MAX - 1)) begin
                           cy        <= '0;
                           sweep_end <= 1'b1;
                        end else begin
                           cy <= cy + 7'd1;
                        end
                     end else begin
                        cx <= cx + 8'd1;
                     end
                  end
               end
               IDLE: begin
                  plot <= 1'b0;
                  busy <= 1'b0;
                  if (tick || pending) begin
                     pending <= 1'b0;
                     snap2   <= p2;
                     snap3   <= p3;
                     snap4   <= p4;
                     x       <= p1[14:7];
                     y       <= p1[6:0];
                     colour  <= P1_COLOUR;
                     plot    <= on_screen(p1);
                     busy    <= 1'b1;
                     state   <= DRAW_P1;
                  end
               end
               DRAW_P1: begin
                  pending <= pending | tick;
                  x       <= snap2[14:7];
                  y       <= snap2[6:0];
                  colour  <= P2_COLOUR;
                  plot    <= on_screen(snap2);
                  state   <= DRAW_P2;
               end
               DRAW_P2: begin
                  pending <= pending | tick;
                  x       <= snap3[14:7];
                  y       <= snap3[6:0];
                  colour  <= P3_COLOUR;
                  plot    <= on_screen(snap3);
                  state   <= DRAW_P3;
               end
               DRAW_P3: begin
                  pending <= pending | tick;
                  x       <= snap4[14:7];
                  y       <= snap4[6:0];
                  colour  <= P4_COLOUR;
                  plot    <= on_screen(snap4);
                  state   <= DRAW_P4;
               end
               DRAW_P4: begin
                  pending <= pending | tick;
                  plot    <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
               default: begin
                  state     <= CLEAR;
                  cx        <= '0;
                  cy        <= '0;
                  sweep_end <= 1'b0;
                  pending   <= 1'b0;
                  plot      <= 1'b0;
                  busy      <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_plot_sequencer.sv
module tb_plot_sequencer;

   localparam int NX = 160;
   localparam int NY = 120;

   logic        CLOCK_50 = 1'b0;
   logic        reset, clear_req, tick;
   logic [14:0] p1, p2, p3, p4;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot, busy, clear_done;

   int checks = 0;
   int failures = 0;
   logic [2:0] pcol [4] = '{3'b001, 3'b010, 3'b100, 3'b110};

   plot_sequencer #(.X_MAX(160), .Y_MAX(120)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .clear_req(clear_req), .tick(tick),
      .p1(p1), .p2(p2), .p3(p3), .p4(p4),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
      .clear_done(clear_done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   // outputs are sampled 1 time unit after the active edge
   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic bit on_scr(input logic [14:0] p);
      return (int'(p[14:7]) < NX) && (int'(p[6:0]) < NY);
   endfunction

   function automatic logic [14:0] rand_pos(input bit allow_off);
      logic [14:0] p;
      if (allow_off) p = 15'($urandom);
      else p = {8'($urandom_range(NX - 1)), 7'($urandom_range(NY - 1))};
      return p;
   endfunction

   // Expects pixel 0 on the outputs now; walks the whole sweep and the done pulse.
   task automatic check_sweep(input string tag);
      int bad = 0;
      int first_bad = -1;
      int plots = 0;
      for (int i = 0; i < NX * NY; i++) begin
         if (plot === 1'b1) plots++;
         if (plot !== 1'b1 || colour !== 3'b000 || x !== 8'(i % NX) ||
             y !== 7'(i / NX) || busy !== 1'b1 || clear_done !== 1'b0) begin
            if (first_bad < 0) first_bad = i;
            bad++;
         end
         cyc();
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL %s sweep: %0d bad pixels, first at index %0d, required 0 bad", tag, bad, first_bad);
      end
      checks++;
      if (plots !== NX * NY) begin
         failures++;
         $display("FAIL %s plot_count: got %0d required %0d", tag, plots, NX * NY);
      end
      checks++;
      if ({clear_done, plot, busy} !== 3'b100) begin
         failures++;
         $display("FAIL %s done_cycle: {clear_done,plot,busy}=%b required 100", tag, {clear_done, plot, busy});
      end
      cyc();
      checks++;
      if ({clear_done, plot, busy} !== 3'b000) begin
         failures++;
         $display("FAIL %s after_done: {clear_done,plot,busy}=%b required 000", tag, {clear_done, plot, busy});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      checks++;
      if ({x, y, colour, plot, busy, clear_done} !== {8'd0, 7'd0, 3'b000, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_values: x=%0d y=%0d colour=%b plot=%b busy=%b done=%b required 0 0 000 0 1 0",
                  x, y, colour, plot, busy, clear_done);
      end
      reset = 1'b0;
      cyc();
      check_sweep("reset");
   endtask

   // Idle on entry; pulses tick with the given positions and checks the 4 draw cycles.
   task automatic test_draw(input logic [14:0] a, b, c, d, input bit scramble, input string tag);
      logic [14:0] pos [4];
      bit ep;
      pos = '{a, b, c, d};
      p1 = a; p2 = b; p3 = c; p4 = d;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (scramble) begin
         p1 = rand_pos(1); p2 = rand_pos(1); p3 = rand_pos(1); p4 = rand_pos(1);
      end
      for (int k = 0; k < 4; k++) begin
         ep = on_scr(pos[k]);
         checks++;
         if (busy !== 1'b1 || plot !== ep) begin
            failures++;
            $display("FAIL %s draw%0d_ctl: busy=%b plot=%b required 1 %b", tag, k + 1, busy, plot, ep);
         end
         if (ep) begin
            checks++;
            if ({x, y, colour} !== {pos[k][14:7], pos[k][6:0], pcol[k]}) begin
               failures++;
               $display("FAIL %s draw%0d_px: (%0d,%0d) c=%b required (%0d,%0d) c=%b", tag, k + 1,
                        x, y, colour, pos[k][14:7], pos[k][6:0], pcol[k]);
            end
         end
         cyc();
      end
      checks++;
      if ({plot, busy} !== 2'b00) begin
         failures++;
         $display("FAIL %s draw_end: plot=%b busy=%b required 0 0", tag, plot, busy);
      end
   endtask

   task automatic test_random_draws();
      for (int n = 0; n < 24; n++)
         test_draw(rand_pos(n % 3 == 0), rand_pos(n % 4 == 1), rand_pos(n % 5 == 2),
                   rand_pos(n % 2 == 1), 1'b1, "random");
   endtask

   task automatic test_back_to_back();
      logic [14:0] a [4];
      logic [14:0] b [4];
      for (int k = 0; k < 4; k++) begin
         a[k] = rand_pos(0);
         b[k] = rand_pos(0);
      end
      p1 = a[0]; p2 = a[1]; p3 = a[2]; p4 = a[3];
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({plot, busy, x, y, colour} !== {2'b11, a[k][14:7], a[k][6:0], pcol[k]}) begin
            failures++;
            $display("FAIL b2b first%0d: plot=%b busy=%b (%0d,%0d) c=%b required 1 1 (%0d,%0d) c=%b", k + 1,
                     plot, busy, x, y, colour, a[k][14:7], a[k][6:0], pcol[k]);
         end
         if (k == 1) begin
            p1 = b[0]; p2 = b[1]; p3 = b[2]; p4 = b[3];
            tick = 1'b1;
         end
         cyc();
         tick = 1'b0;
      end
      checks++;
      if ({plot, busy} !== 2'b00) begin
         failures++;
         $display("FAIL b2b gap: plot=%b busy=%b required 0 0", plot, busy);
      end
      cyc();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({plot, busy, x, y, colour} !== {2'b11, b[k][14:7], b[k][6:0], pcol[k]}) begin
            failures++;
            $display("FAIL b2b second%0d: plot=%b busy=%b (%0d,%0d) c=%b required 1 1 (%0d,%0d) c=%b", k + 1,
                     plot, busy, x, y, colour, b[k][14:7], b[k][6:0], pcol[k]);
         end
         cyc();
      end
      checks++;
      if ({plot, busy} !== 2'b00) begin
         failures++;
         $display("FAIL b2b end: plot=%b busy=%b required 0 0", plot, busy);
      end
   endtask

   task automatic check_quiet(input string tag);
      int plots = 0;
      for (int i = 0; i < 8; i++) begin
         if (plot !== 1'b0 || busy !== 1'b0) plots++;
         cyc();
      end
      checks++;
      if (plots !== 0) begin
         failures++;
         $display("FAIL %s quiet: %0d active cycles required 0", tag, plots);
      end
   endtask

   task automatic test_clear_req();
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      for (int i = 0; i < 3 * NX + 5; i++) cyc();
      checks++;
      if ({plot, x, y} !== {1'b1, 8'd5, 7'd3}) begin
         failures++;
         $display("FAIL clear_req position: plot=%b (%0d,%0d) required 1 (5,3)", plot, x, y);
      end
      // tick in the same cycle must lose to clear_req and leave no pending draw
      clear_req = 1'b1;
      tick = 1'b1;
      cyc();
      clear_req = 1'b0;
      tick = 1'b0;
      check_sweep("clear_req");
      check_quiet("clear_req");
   endtask

   task automatic test_reset_mid_draw();
      p1 = rand_pos(0); p2 = rand_pos(0); p3 = rand_pos(0); p4 = rand_pos(0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      reset = 1'b1;
      tick = 1'b1;
      cyc();
      checks++;
      if ({x, y, colour, plot, busy, clear_done} !== {8'd0, 7'd0, 3'b000, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL mid_draw_reset: x=%0d y=%0d colour=%b plot=%b busy=%b done=%b required 0 0 000 0 1 0",
                  x, y, colour, plot, busy, clear_done);
      end
      reset = 1'b0;
      tick = 1'b0;
      cyc();
      check_sweep("mid_draw_reset");
      check_quiet("mid_draw_reset");
   endtask

   initial begin
      reset = 1'b1; clear_req = 1'b0; tick = 1'b0;
      p1 = '0; p2 = '0; p3 = '0; p4 = '0;
      test_reset();
      test_draw({8'd10, 7'd20}, {8'd30, 7'd40}, {8'd50, 7'd60}, {8'd70, 7'd80}, 1'b0, "fixed");
      test_draw({8'd10, 7'd20}, {8'd30, 7'd40}, {8'd200, 7'd60}, {8'd70, 7'd80}, 1'b0, "p3_off");
      test_draw({8'd159, 7'd119}, {8'd160, 7'd0}, {8'd0, 7'd120}, {8'd0, 7'd0}, 1'b1, "edges");
      test_random_draws();
      test_back_to_back();
      test_clear_req();
      test_reset_mid_draw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
